// File: rtl/pc_redirect_unit.sv
// Fetch-stage program counter with prioritised redirects and a one-entry
// pending-redirect buffer. A redirect that arrives while fetch is stalled is
// parked in the buffer and applied on the first edge with stall released.
module pc_redirect_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        IDX_W      = 26,
  parameter int unsigned        OFF_W      = 16,
  parameter int unsigned        ALIGN      = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(32'h8000_0180)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [IDX_W-1:0]  jump_idx,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_pc4,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              exc_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect_taken,
  output logic              pending,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(1) << ALIGN;
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = INSTR_BYTES - ADDR_W'(1);
  // Upper PC bits kept by a pseudo-direct jump (the "page" of pc_plus4).
  localparam logic [ADDR_W-1:0] PAGE_MASK   =
      ~((ADDR_W'(1) << (IDX_W + ALIGN)) - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redir_buf_q, redir_buf_d;
  logic              pending_q, pending_d;
  logic              redirect_taken_q, redirect_taken_d;
  logic              addr_err_q, addr_err_d;

  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] br_off_sext;
  logic              jr_ok;
  logic              live_req;
  logic [ADDR_W-1:0] live_tgt;

  assign pc_plus4 = pc_q + INSTR_BYTES;

  // Candidate redirect targets and the winning live request.
  always_comb begin
    jump_tgt    = (pc_plus4 & PAGE_MASK) | (ADDR_W'(jump_idx) << ALIGN);
    br_off_sext = ADDR_W'($signed(br_off));
    br_tgt      = br_pc4 + (br_off_sext << ALIGN);
    jr_ok       = jr_valid && ((jr_target & ALIGN_MASK) == '0);
    live_req    = 1'b1;
    live_tgt    = '0;
    if (br_valid) begin
      live_tgt = br_tgt;
    end else if (jr_ok) begin
      live_tgt = jr_target;
    end else if (jump_valid) begin
      live_tgt = jump_tgt;
    end else begin
      live_req = 1'b0;
    end
  end

  // Next-state selection: exception, live redirect, buffered redirect, advance, hold.
  always_comb begin
    pc_d             = pc_q;
    redir_buf_d      = redir_buf_q;
    pending_d        = pending_q;
    redirect_taken_d = 1'b0;
    // A misaligned jr is reported even if a higher-priority request wins.
    addr_err_d       = jr_valid && !jr_ok;
    if (exc_valid) begin
      pc_d             = EXC_VECTOR;
      pending_d        = 1'b0;
      redirect_taken_d = 1'b1;
    end else if (!stall && live_req) begin
      pc_d             = live_tgt;
      pending_d        = 1'b0;
      redirect_taken_d = 1'b1;
    end else if (!stall && pending_q) begin
      pc_d             = redir_buf_q;
      pending_d        = 1'b0;
      redirect_taken_d = 1'b1;
    end else if (!stall) begin
      pc_d = pc_plus4;
    end else if (live_req) begin
      // Newest request overwrites the buffer: it comes from the older instruction.
      redir_buf_d = live_tgt;
      pending_d   = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q             <= RESET_PC;
      redir_buf_q      <= '0;
      pending_q        <= 1'b0;
      redirect_taken_q <= 1'b0;
      addr_err_q       <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      redir_buf_q      <= redir_buf_d;
      pending_q        <= pending_d;
      redirect_taken_q <= redirect_taken_d;
      addr_err_q       <= addr_err_d;
    end
  end

  assign pc             = pc_q;
  assign pending        = pending_q;
  assign redirect_taken = redirect_taken_q;
  assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: a default 32-bit instance and a 16-bit instance
// driven from the same stimulus, both compared every cycle against a model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, jump_valid, jr_valid, br_valid, exc_valid;
  logic [25:0] jump_idx;
  logic [31:0] jr_target, br_pc4;
  logic [15:0] br_off;

  logic [31:0] pc, pc_plus4;
  logic        redirect_taken, pending, addr_err;
  logic [15:0] s_pc, s_pc_plus4;
  logic        s_redirect_taken, s_pending, s_addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_redirect_unit u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .jump_valid     (jump_valid),
    .jump_idx       (jump_idx),
    .jr_valid       (jr_valid),
    .jr_target      (jr_target),
    .br_valid       (br_valid),
    .br_pc4         (br_pc4),
    .br_off         (br_off),
    .exc_valid      (exc_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .redirect_taken (redirect_taken),
    .pending        (pending),
    .addr_err       (addr_err)
  );

  pc_redirect_unit #(
    .ADDR_W     (16),
    .IDX_W      (10),
    .OFF_W      (12),
    .ALIGN      (2),
    .RESET_PC   (16'h0000),
    .EXC_VECTOR (16'h0180)
  ) u_dut16 (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .jump_valid     (jump_valid),
    .jump_idx       (jump_idx[9:0]),
    .jr_valid       (jr_valid),
    .jr_target      (jr_target[15:0]),
    .br_valid       (br_valid),
    .br_pc4         (br_pc4[15:0]),
    .br_off         (br_off[11:0]),
    .exc_valid      (exc_valid),
    .pc             (s_pc),
    .pc_plus4       (s_pc_plus4),
    .redirect_taken (s_redirect_taken),
    .pending        (s_pending),
    .addr_err       (s_addr_err)
  );

  typedef struct {
    longint pc;
    bit     pend;
    longint bufv;
    bit     rt;
    bit     err;
  } mstate_t;

  mstate_t mb, ms;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t model_reset();
    mstate_t r;
    r.pc = 0; r.pend = 0; r.bufv = 0; r.rt = 0; r.err = 0;
    return r;
  endfunction

  // Architectural rules in plain integer arithmetic; aw/iw/ow are the widths.
  function automatic mstate_t model_step(input mstate_t s, input int aw, input int iw,
                                         input int ow, input longint excv_addr);
    mstate_t n;
    longint modv, page, pc4, jt, so, bt, jrt, tgt;
    bit     jr_ok, have;
    n     = s;
    modv  = longint'(1) << aw;
    page  = longint'(1) << (iw + 2);
    pc4   = (s.pc + 4) % modv;
    jt    = (pc4 / page) * page + (longint'(jump_idx) % (longint'(1) << iw)) * 4;
    so    = longint'(br_off) % (longint'(1) << ow);
    if (so >= (longint'(1) << (ow - 1))) so = so - (longint'(1) << ow);
    bt    = (longint'(br_pc4) % modv + so * 4) % modv;
    if (bt < 0) bt = bt + modv;
    jrt   = longint'(jr_target) % modv;
    jr_ok = jr_valid && (jrt % 4 == 0);
    n.rt  = 0;
    n.err = jr_valid && !jr_ok;
    have  = 1;
    tgt   = 0;
    if (br_valid)        tgt = bt;
    else if (jr_ok)      tgt = jrt;
    else if (jump_valid) tgt = jt;
    else                 have = 0;
    if (exc_valid) begin
      n.pc = excv_addr; n.pend = 0; n.rt = 1;
    end else if (!stall && have) begin
      n.pc = tgt; n.pend = 0; n.rt = 1;
    end else if (!stall && s.pend) begin
      n.pc = s.bufv; n.pend = 0; n.rt = 1;
    end else if (!stall) begin
      n.pc = pc4;
    end else if (have) begin
      n.bufv = tgt; n.pend = 1;
    end
    return n;
  endfunction

  task automatic compare_all();
    check("pc",        pc,                     32'(mb.pc));
    check("pc_plus4",  pc_plus4,               32'((mb.pc + 4) % (longint'(1) << 32)));
    check("pending",   {31'b0, pending},       {31'b0, mb.pend});
    check("redirect",  {31'b0, redirect_taken},{31'b0, mb.rt});
    check("addr_err",  {31'b0, addr_err},      {31'b0, mb.err});
    check("pc16",      {16'b0, s_pc},          32'(ms.pc));
    check("pc16_plus4",{16'b0, s_pc_plus4},    32'((ms.pc + 4) % 65536));
    check("pending16", {31'b0, s_pending},     {31'b0, ms.pend});
    check("redirect16",{31'b0, s_redirect_taken}, {31'b0, ms.rt});
    check("addr_err16",{31'b0, s_addr_err},    {31'b0, ms.err});
  endtask

  task automatic idle_inputs();
    stall = 0; jump_valid = 0; jr_valid = 0; br_valid = 0; exc_valid = 0;
    jump_idx = '0; jr_target = '0; br_pc4 = '0; br_off = '0;
  endtask

  // One clock edge: advance the models with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    mb = model_step(mb, 32, 26, 16, 64'h8000_0180);
    ms = model_step(ms, 16, 10, 12, 64'h0180);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 reset_n = 0;
    #1;
    mb = model_reset();
    ms = model_reset();
    check("async_rst_pc",      pc,               32'h0);
    check("async_rst_pending", {31'b0, pending}, 32'h0);
    compare_all();
    #3 reset_n = 1;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    mb = model_reset();
    ms = model_reset();
    @(posedge clk);
    #3 reset_n = 1;
    #1;
    check("rst_pc",       pc,                       32'h0);
    check("rst_pending",  {31'b0, pending},         32'h0);
    check("rst_redirect", {31'b0, redirect_taken},  32'h0);
    check("rst_addr_err", {31'b0, addr_err},        32'h0);
    compare_all();

    // Free run.
    repeat (3) cycle();
    check("freerun_pc", pc, 32'h0000_000C);
    check("freerun_rt", {31'b0, redirect_taken}, 32'h0);

    // Pseudo-direct jump.
    jr_valid = 1; jr_target = 32'h4000_0010;
    cycle();
    idle_inputs();
    jump_valid = 1; jump_idx = 26'h000_0100;
    cycle();
    check("jump_tgt",   pc,   32'h4000_0400);
    check("jump_tgt16", {16'b0, s_pc}, 32'h0000_0400);
    check("jump_rt",    {31'b0, redirect_taken}, 32'h1);
    idle_inputs();
    jr_valid = 1; jr_target = 32'h5000_3010;
    cycle();
    idle_inputs();
    jump_valid = 1; jump_idx = 26'h000_03FF;
    cycle();
    check("jump_page",   pc,            32'h5000_0FFC);
    check("jump_page16", {16'b0, s_pc}, 32'h0000_3FFC);

    // Branch beats jump; negative offsets and wrap-around.
    idle_inputs();
    br_valid = 1; br_pc4 = 32'h0000_0100; br_off = 16'hFFFC; jump_valid = 1; jump_idx = 26'h55;
    cycle();
    check("br_over_jump", pc, 32'h0000_00F0);
    br_pc4 = 32'h0000_0004; br_off = 16'hFFFE;
    cycle();
    check("br_wrap", pc, 32'hFFFF_FFFC);
    idle_inputs();
    cycle();
    check("pc_wrap", pc, 32'h0000_0000);

    // Stall with a buffered jr.
    stall = 1; jr_valid = 1; jr_target = 32'h0000_2000;
    cycle();
    jr_valid = 0;
    repeat (2) cycle();
    check("stall_pending", {31'b0, pending}, 32'h1);
    check("stall_hold",    pc, 32'h0000_0000);
    stall = 0;
    cycle();
    check("release_pc",      pc, 32'h0000_2000);
    check("release_pending", {31'b0, pending}, 32'h0);

    // Second variant: jump in stall cycle 2 overwrites the buffer.
    stall = 1; jr_valid = 1; jr_target = 32'h0000_3000;
    cycle();
    jr_valid = 0; jump_valid = 1; jump_idx = 26'h0_0040;
    cycle();
    jump_valid = 0;
    cycle();
    stall = 0;
    cycle();
    check("overwrite_pc", pc, 32'h0000_0100);

    // Exception during stall with a pending redirect.
    stall = 1; jr_valid = 1; jr_target = 32'h0000_4000;
    cycle();
    jr_valid = 0; exc_valid = 1;
    cycle();
    check("exc_pc",      pc, 32'h8000_0180);
    check("exc_pending", {31'b0, pending}, 32'h0);
    idle_inputs();

    // Misaligned jr is rejected.
    jr_valid = 1; jr_target = 32'h0000_2002;
    cycle();
    check("misalign_err", {31'b0, addr_err}, 32'h1);
    check("misalign_pc",  pc, 32'h8000_0184);
    idle_inputs();
    cycle();
    check("err_pulse", {31'b0, addr_err}, 32'h0);

    // Reset mid-stall discards the buffered redirect.
    stall = 1; jr_valid = 1; jr_target = 32'h0000_6000;
    cycle();
    idle_inputs();
    async_reset();
    cycle();
    check("post_rst_pc", pc, 32'h0000_0004);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      jump_valid = ($urandom_range(0, 5) == 0);
      jr_valid   = ($urandom_range(0, 7) == 0);
      br_valid   = ($urandom_range(0, 7) == 0);
      exc_valid  = ($urandom_range(0, 39) == 0);
      jump_idx   = 26'($urandom);
      jr_target  = $urandom;
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
      br_pc4     = $urandom & 32'hFFFF_FFFC;
      br_off     = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised next-PC generator and program-counter register for the fetch stage.
- Generalises pseudo-direct jump-target formation to arbitrary address and index widths.
- Adds branch-relative, register-indirect and exception redirects with fixed priority, stall hold, and a one-entry pending-redirect buffer, so a redirect that arrives during a stall is not lost.

Parameters:
ADDR_W, 32, PC/address width in bits
IDX_W, 26, jump instruction-index field width
OFF_W, 16, branch offset field width (word offset, signed)
ALIGN, 2, log2 of instruction size; low ALIGN bits of every PC are zero
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, exception handler address
Legal configurations: IDX_W+ALIGN < ADDR_W; OFF_W+ALIGN <= ADDR_W.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hold PC (fetch stalled)
jump_valid  input  1  ID-stage pseudo-direct jump request
jump_idx  input  IDX_W  jump index field
jr_valid  input  1  register-indirect jump request
jr_target  input  ADDR_W  register-indirect target
br_valid  input  1  taken-branch request (resolved by the older instruction)
br_pc4  input  ADDR_W  PC+4 of the branch instruction
br_off  input  OFF_W  signed word offset
exc_valid  input  1  exception request
pc  output  ADDR_W  current fetch PC
pc_plus4  output  ADDR_W  pc + (1<<ALIGN), combinational
redirect_taken  output  1  1-cycle pulse: pc was loaded from a redirect this edge
pending  output  1  buffered redirect awaiting release of stall
addr_err  output  1  1-cycle pulse: misaligned jr_target rejected

Behaviour:
- Reset (reset_n=0, asynchronous): pc=RESET_PC; pending=0; redirect_taken=0; addr_err=0; pending buffer cleared. First edge after deassertion advances normally.
- Target formation (combinational):
  - jump: {pc_plus4[ADDR_W-1:IDX_W+ALIGN], jump_idx, ALIGN'b0}
  - branch: br_pc4 + (sign_extend(br_off) << ALIGN), truncated mod 2^ADDR_W (wrap-around is legal)
  - jr: jr_target
  - exc: EXC_VECTOR
- pc_plus4 wraps mod 2^ADDR_W; pc = all-ones-aligned advances to 0.
- jr validity: a jr request with jr_target[ALIGN-1:0] != 0 is rejected. Rejection means addr_err pulses on the next edge and the request is treated as absent.
- Priority for same-cycle requests: exc > br > jr > jump. Lower-priority requests are discarded.
- Per rising edge:
  1. exc_valid=1: pc<=EXC_VECTOR regardless of stall; pending cleared; redirect_taken=1.
  2. Else if stall=0 and a live request exists: pc<=winning target; redirect_taken=1; pending cleared.
  3. Else if stall=0 and pending=1: pc<=buffered target; redirect_taken=1; pending<=0.
  4. Else if stall=0: pc<=pc_plus4; redirect_taken=0.
  5. Else (stall=1, no exc): pc holds; redirect_taken=0.
     - A live request is written into the buffer and pending<=1.
     - A new request overwrites an existing buffered one, because the newer redirect belongs to the older instruction in flight.
- A live request always beats a buffered one when stall=0 (case 2 over case 3).
- Latency: request to pc update is one edge when not stalled. With a stall, the update happens on the first edge with stall=0.
- Reset mid-stall with pending=1 discards the buffered redirect.
- redirect_taken and addr_err are registered outputs, high for exactly one cycle per event.

Test Plan:
- Reset then free-run, stall=0, no requests: pc sequence 0x0, 0x4, 0x8, 0xC; redirect_taken stays 0.
- pc=0x4000_0010, jump_valid=1, jump_idx=26'h000_0100: next pc=0x4000_0400, redirect_taken pulses.
- Same-cycle br_valid (br_pc4=0x0000_0100, br_off=16'hFFFC) and jump_valid: pc=0x0000_00F0, jump ignored. Repeat with br_pc4=0x0000_0004, br_off=16'hFFFE: pc wraps to 0xFFFF_FFFC.
- stall=1 for 3 cycles with jr_valid=1, jr_target=0x0000_2000 on cycle 1:
  - pc holds and pending=1 during the stall.
  - On release, pc=0x0000_2000 in one edge, pending=0.
  - Second variant: jump_valid in stall cycle 2 overwrites the buffer and that jump target is taken.
- exc_valid=1 while stall=1 and pending=1: pc=0x8000_0180 at the next edge, pending=0.
- jr_target=0x0000_2002: addr_err pulses, pc advances to pc+4.
- Assert reset_n=0 asynchronously mid-cycle while pending=1: pc=RESET_PC immediately, pending=0.
- Build with ADDR_W=16, IDX_W=10: jump target={pc_plus4[15:12], idx, 2'b0}.
